// File: rtl/deint_pkg.sv
// Shared constants and FSM encoding for the QPP deinterleaver buffer.
package deint_pkg;

  localparam int unsigned KMAX_C = 6144;
  localparam int unsigned AW_C   = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/deint_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module deint_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned Depth = 6144,
  parameter int unsigned AW    = 13
) (
  input  logic          clk,
  input  logic          dff_clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [Depth];

  // Array contents are deliberately never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // The read register doubles as the block's output data register.
  always_ff @(posedge clk) begin
    if (!dff_clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/generaldff.sv
// Enabled register with synchronous active-low clear.
module generaldff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         dff_clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!dff_clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/deinterleaver_buffer.sv
// Writes an interleaved block to slots Pi(i), then streams it out in natural order.
module deinterleaver_buffer
  import deint_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned KMAX = KMAX_C,
  parameter int unsigned AW   = AW_C
) (
  input  logic          clk,
  input  logic          dff_clr,
  input  logic [AW-1:0] K_i,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done,
  output logic          err_addr
);

  state_e        state;
  logic [AW-1:0] k_r;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_ptr;

  logic start_acc, in_fire, addr_ok, wr_en, rd_en, out_fire, last_out;

  assign start_acc = start && (state == IDLE);
  assign in_fire   = in_valid && in_ready;
  assign addr_ok   = in_addr < k_r;
  assign wr_en     = in_fire && addr_ok;
  assign rd_en     = (state == DRAIN) && (!out_valid || out_ready) && (rd_ptr < k_r);
  assign out_fire  = out_valid && out_ready;
  assign last_out  = out_fire && (out_idx == k_r - AW'(1));

  generaldff #(.W(AW)) u_k_reg (
    .clk     (clk),
    .dff_clr (dff_clr),
    .en      (start_acc),
    .d       (K_i),
    .q       (k_r)
  );

  deint_ram #(.DW(DW), .Depth(KMAX), .AW(AW)) u_ram (
    .clk     (clk),
    .dff_clr (dff_clr),
    .we      (wr_en),
    .waddr   (in_addr),
    .wdata   (in_data),
    .re      (rd_en),
    .raddr   (rd_ptr),
    .rdata   (out_data)
  );

  always_ff @(posedge clk) begin
    if (!dff_clr) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_addr  <= 1'b0;
      out_idx   <= '0;
      wr_cnt    <= '0;
      rd_ptr    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            err_addr <= 1'b0;
            wr_cnt   <= '0;
            rd_ptr   <= '0;
          end
        end
        FILL: begin
          if (in_fire) begin
            wr_cnt <= wr_cnt + AW'(1);
            // Out-of-range beats are dropped but still count toward K.
            if (!addr_ok) begin
              err_addr <= 1'b1;
            end
            if (wr_cnt + AW'(1) == k_r) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (rd_en) begin
            rd_ptr    <= rd_ptr + AW'(1);
            out_idx   <= rd_ptr;
            out_valid <= 1'b1;
          end else if (out_fire) begin
            out_valid <= 1'b0;
          end
          if (last_out) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deinterleaver_buffer.sv
// Directed bench for deinterleaver_buffer using QPP-permuted blocks.
module tb_deinterleaver_buffer;

  logic        clk = 1'b0;
  logic        dff_clr;
  logic [12:0] K_i;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [12:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [12:0] out_idx;
  logic        busy;
  logic        done;
  logic        err_addr;

  int checks   = 0;
  int failures = 0;

  deinterleaver_buffer #(.DW(8), .KMAX(6144), .AW(13)) dut (
    .clk       (clk),
    .dff_clr   (dff_clr),
    .K_i       (K_i),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .err_addr  (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int pi(input int i, input int k, input int f1, input int f2);
    longint t;
    t = (longint'(f1) * i + longint'(f2) * i * i) % k;
    return int'(t);
  endfunction

  task automatic start_block(input int k);
    K_i   = 13'(k);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_ready", in_ready, 1);
    check("start_busy", busy, 1);
    check("start_err_clear", err_addr, 0);
  endtask

  task automatic fill(input int k, input int beats, input int f1, input int f2, input int gap_pct,
                      input int bad_beat, input int bad_addr, input bit start_pulse);
    int  i = 0;
    int  guard = 0;
    bit  v;
    while (i < beats && guard < beats * 10 + 100) begin
      v        = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_addr  = 13'(pi(i, k, f1, f2));
      in_data  = 8'(pi(i, k, f1, f2));
      if (i == bad_beat) in_addr = 13'(bad_addr);
      start = start_pulse && (i == 10);
      K_i   = start_pulse ? 13'd100 : 13'(k);
      check("fill_in_ready", in_ready, 1);
      if (v && i == bad_beat) check("err_before_bad", err_addr, 0);
      tick();
      if (v && i == bad_beat) check("err_after_bad", err_addr, 1);
      if (v) i++;
      guard++;
    end
    in_valid = 1'b0;
    start    = 1'b0;
    K_i      = 13'(k);
    check("fill_beats", i, beats);
  endtask

  task automatic drain(input int k, input bit bp, input bit exp_err, input int skip_idx,
                       input bit start_pulse);
    int n = 0;
    int cyc = 0;
    int first = -1;
    int dones = 0;
    check("drain_in_ready", in_ready, 0);
    check("drain_out_valid_init", out_valid, 0);
    while (n < k && cyc < 4 * k + 50) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      start     = start_pulse && (cyc == 3);
      if (start_pulse) K_i = 13'd100;
      if (start_pulse && cyc == 4) check("busy_ignored_start", busy, 1);
      if (out_valid) begin
        if (first < 0) first = cyc;
        check("out_idx", out_idx, n);
        if (n != skip_idx) check("out_data", out_data, n & 255);
        check("err_in_drain", err_addr, exp_err);
        if (out_ready) n++;
      end
      if (done) dones++;
      tick();
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("beat_count", n, k);
    check("first_latency", first, 1);
    if (!bp) check("drain_cycles", cyc, k + 1);
    check("early_done", dones, 0);
    check("done_pulse", done, 1);
    check("busy_after", busy, 0);
    check("out_valid_after", out_valid, 0);
    tick();
    check("done_one_shot", done, 0);
    check("err_after", err_addr, exp_err);
  endtask

  initial begin
    dff_clr   = 1'b0;
    K_i       = '0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_addr   = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", out_idx, 0);
    dff_clr = 1'b1;
    tick();

    // Natural ordering, no back-pressure
    start_block(40);
    fill(40, 40, 3, 10, 0, -1, 0, 1'b0);
    drain(40, 1'b0, 1'b0, -1, 1'b0);

    // Back-pressure pattern 1,0,0,1
    start_block(40);
    fill(40, 40, 3, 10, 0, -1, 0, 1'b0);
    drain(40, 1'b1, 1'b0, -1, 1'b0);

    // Beat 5 (Pi=25) redirected to out-of-range address 45; slot 25 left stale
    start_block(40);
    fill(40, 40, 3, 10, 0, 5, 45, 1'b0);
    drain(40, 1'b0, 1'b1, 25, 1'b0);

    // Reset after 20 fill beats; start_block also checks err_addr clears
    start_block(40);
    fill(40, 20, 3, 10, 0, -1, 0, 1'b0);
    dff_clr = 1'b0;
    tick();
    dff_clr = 1'b1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_err", err_addr, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_idx", out_idx, 0);
    tick();
    check("midrst_no_done", done, 0);
    check("midrst_idle_valid", out_valid, 0);

    start_block(40);
    fill(40, 40, 3, 10, 0, -1, 0, 1'b0);
    drain(40, 1'b0, 1'b0, -1, 1'b0);

    // start with K_i=100 during FILL and DRAIN must be ignored
    start_block(40);
    fill(40, 40, 3, 10, 0, -1, 0, 1'b1);
    drain(40, 1'b0, 1'b0, -1, 1'b1);

    // Maximum block with ~30% input gaps
    start_block(6144);
    fill(6144, 6144, 263, 480, 30, -1, 0, 1'b0);
    drain(6144, 1'b0, 1'b0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
